tx_frame_arbiter: RTL



---
 rtl/tx_frame_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
// ----------------
// Frame-granular two-requester arbiter owning the write port of the TX byte
// FIFO. Requester 0 is the MAC client data path, requester 1 the control-frame
// generator. A grant is locked for a whole frame (bytes are never interleaved)
// and frames longer than MAX_LEN bytes are truncated: the MAX_LEN-th byte is
// marked last, and the remainder of the source frame is accepted and dropped.
//
// Ports:
//   wclk, wrst              write-domain clock, synchronous active-high reset
//   s0_* / s1_*             requester byte streams (valid/ready/data/last)
//   m_*                     FIFO write port (wvalid/wready/wdata/wlast)
//   grant                   one-hot current owner, 00 when idle
//   busy                    high while a frame is being passed or drained
//   trunc                   one-cycle pulse after a frame has been truncated
//
// Build option:
//   TX_ARB_STRICT_PRIO_EN   when defined, requester 1 always wins a tie in
//                           IDLE; otherwise ties are resolved round-robin.

module tx_frame_arbiter #(
    parameter int MAX_LEN = 1518
) (
    input  logic       wclk,
    input  logic       wrst,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    input  logic       s1_valid,
    output logic       s1_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic [1:0] grant,
    output logic       busy,
    output logic       trunc
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trunc_q, trunc_d;

    logic          sel_s;        // 0: requester 0 owns the port, 1: requester 1
    logic          req_valid_s;
    logic [7:0]    req_data_s;
    logic          req_last_s;
    logic          force_last_s;
    logic          win_s;        // IDLE arbitration result (requester index)

    // Multiplex the granted requester and evaluate the length guard.
    always_comb begin
        sel_s        = grant_q[1];
        req_valid_s  = sel_s ? s1_valid : s0_valid;
        req_data_s   = sel_s ? s1_data  : s0_data;
        req_last_s   = sel_s ? s1_last  : s0_last;
        // Counter holds bytes already sent; this beat would be byte MAX_LEN.
        force_last_s = (cnt_q == CW'(MAX_LEN - 1));
    end

    // Pick the winner of a new frame while idle.
    always_comb begin
`ifdef TX_ARB_STRICT_PRIO_EN
        // Control frames win every tie; a lone s0 request still wins.
        win_s = s1_valid;
`else
        // On a tie the side that did not send the previous frame wins.
        if (s0_valid && s1_valid) begin
            win_s = ~last_owner_q;
        end else begin
            win_s = s1_valid;
        end
`endif
    end

    // Next-state and datapath outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        trunc_d      = 1'b0;
        m_valid      = 1'b0;
        m_data       = 8'h00;
        m_last       = 1'b0;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_d = win_s ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    grant_d = 2'b00;
                end
            end

            XFER: begin
                m_valid  = req_valid_s;
                m_data   = req_data_s;
                m_last   = req_last_s | force_last_s;
                s0_ready = ~sel_s & m_ready;
                s1_ready =  sel_s & m_ready;
                if (req_valid_s && m_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (req_last_s) begin
                        // Natural end, including a last exactly on byte MAX_LEN.
                        last_owner_d = sel_s;
                        grant_d      = 2'b00;
                        state_d      = IDLE;
                    end else if (force_last_s) begin
                        // Source frame is still going: cut it and swallow the rest.
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = XFER;
                end
            end

            DRAIN: begin
                // Grant stays held so the tail bytes come from the same source.
                s0_ready = ~sel_s;
                s1_ready =  sel_s;
                if (req_valid_s && req_last_s) begin
                    last_owner_d = sel_s;
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            trunc_q      <= trunc_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
    assign trunc = trunc_q;

endmodule
